// File: rtl/neogeo_burst_pkg.sv
// Shared types and widths for the graphics burst-read responder.
package neogeo_burst_pkg;

   localparam int unsigned BURST_ADDR_W = 26;
   localparam int unsigned BURST_LEN_W  = 11;
   localparam int unsigned HALF_W       = 16;
   localparam int unsigned BEAT_W       = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } burst_state_t;

endpackage

// File: rtl/burst_pack.sv
// Packs returned halfwords into beats: pairs into 32-bit words, or one
// halfword per beat. An odd trailing halfword goes out zero-padded.
module burst_pack
   import neogeo_burst_pkg::*;
(
   input  logic              CLK,
   input  logic              nRESET,
   input  logic [HALF_W-1:0] hw,
   input  logic              hw_valid,
   input  logic              mode_32,
   input  logic              last,
   output logic [BEAT_W-1:0] beat,
   output logic              beat_valid
);

   logic [HALF_W-1:0] hi_q;
   logic              phase;

   // Hold the first halfword of a pair, emit a registered beat when complete.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         beat       <= '0;
         beat_valid <= 1'b0;
         hi_q       <= '0;
         phase      <= 1'b0;
      end else begin
         beat_valid <= 1'b0;
         if (hw_valid) begin
            if (!mode_32) begin
               beat       <= {HALF_W'(0), hw};
               beat_valid <= 1'b1;
               phase      <= 1'b0;
            end else if (phase) begin
               beat       <= {hi_q, hw};
               beat_valid <= 1'b1;
               phase      <= 1'b0;
            end else if (last) begin
               beat       <= {hw, HALF_W'(0)};
               beat_valid <= 1'b1;
            end else begin
               hi_q  <= hw;
               phase <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sdram_burst_responder.sv
// Burst-read target: splits a burst into pipelined halfword reads,
// tracks in-flight reads and hands responses to the beat packer.
module sdram_burst_responder
   import neogeo_burst_pkg::*;
#(
   parameter int unsigned ADDR_W  = BURST_ADDR_W,
   parameter int unsigned LEN_W   = BURST_LEN_W,
   parameter int unsigned MAX_OUT = 4
) (
   input  logic              CLK,
   input  logic              nRESET,
   input  logic              burst_rd,
   input  logic [ADDR_W-1:0] burst_addr,
   input  logic [LEN_W-1:0]  burst_len,
   input  logic              burst_32bit,
   output logic [BEAT_W-1:0] burst_data,
   output logic              burst_data_valid,
   output logic              burst_data_done,
   output logic              burst_busy,
   output logic              burst_overrun,
   output logic              mem_rd,
   output logic [ADDR_W-2:0] mem_addr,
   input  logic              mem_ready,
   input  logic [HALF_W-1:0] mem_q,
   input  logic              mem_q_valid
);

   localparam int unsigned HADDR_W = ADDR_W - 1;
   localparam int unsigned OUT_W   = $clog2(MAX_OUT) + 1;

   burst_state_t       state, state_nxt;
   logic [LEN_W-1:0]   len_q, len_nxt;
   logic [LEN_W-1:0]   issued, issued_nxt;
   logic [LEN_W-1:0]   rcvd, rcvd_nxt;
   logic [OUT_W-1:0]   outst, outst_nxt;
   logic [HADDR_W-1:0] addr_nxt;
   logic               mode_q, mode_nxt;
   logic               mem_rd_nxt, done_nxt, busy_nxt, overrun_nxt;
   logic               rd_accept, q_take, q_last;
   logic               addr_lsb_unused;

   // Byte-address bit 0 never selects anything: reads are halfword granular.
   assign addr_lsb_unused = burst_addr[0];

   assign rd_accept = mem_rd && mem_ready;
   // Responses with nothing outstanding predate a reset and are discarded.
   assign q_take    = mem_q_valid && (outst != '0);
   assign q_last    = (rcvd == (len_q - LEN_W'(1)));

   // Next-state and next-output computation; every output is registered.
   always_comb begin
      state_nxt   = state;
      len_nxt     = len_q;
      mode_nxt    = mode_q;
      addr_nxt    = mem_addr;
      issued_nxt  = issued + LEN_W'(rd_accept);
      rcvd_nxt    = rcvd + LEN_W'(q_take);
      outst_nxt   = outst + OUT_W'(rd_accept) - OUT_W'(q_take);
      overrun_nxt = burst_overrun | (burst_rd && (state != IDLE));

      if (rd_accept) begin
         addr_nxt = mem_addr + HADDR_W'(1);
      end

      case (state)
         IDLE: begin
            if (burst_rd) begin
               len_nxt    = burst_len;
               mode_nxt   = burst_32bit;
               addr_nxt   = burst_addr[ADDR_W-1:1];
               issued_nxt = '0;
               rcvd_nxt   = '0;
               state_nxt  = (burst_len == '0) ? DONE : ISSUE;
            end
         end
         ISSUE: begin
            if (issued == len_q) begin
               state_nxt = (rcvd == len_q) ? DONE : DRAIN;
            end
         end
         DRAIN: begin
            if (rcvd == len_q) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Registered request: look ahead at next-cycle counts so the in-flight cap holds.
      mem_rd_nxt = (state_nxt == ISSUE) && (issued_nxt < len_nxt) &&
                   (outst_nxt < OUT_W'(MAX_OUT));
      done_nxt   = (state_nxt == DONE);
      busy_nxt   = (state_nxt != IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state           <= IDLE;
         len_q           <= '0;
         mode_q          <= 1'b0;
         issued          <= '0;
         rcvd            <= '0;
         outst           <= '0;
         mem_addr        <= '0;
         mem_rd          <= 1'b0;
         burst_busy      <= 1'b0;
         burst_data_done <= 1'b0;
         burst_overrun   <= 1'b0;
      end else begin
         state           <= state_nxt;
         len_q           <= len_nxt;
         mode_q          <= mode_nxt;
         issued          <= issued_nxt;
         rcvd            <= rcvd_nxt;
         outst           <= outst_nxt;
         mem_addr        <= addr_nxt;
         mem_rd          <= mem_rd_nxt;
         burst_busy      <= busy_nxt;
         burst_data_done <= done_nxt;
         burst_overrun   <= overrun_nxt;
      end
   end

   burst_pack u_pack (
      .CLK        (CLK),
      .nRESET     (nRESET),
      .hw         (mem_q),
      .hw_valid   (q_take),
      .mode_32    (mode_q),
      .last       (q_last),
      .beat       (burst_data),
      .beat_valid (burst_data_valid)
   );

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder with a burst-level reference model
// and a latency-programmable in-order memory.
module tb_sdram_burst_responder;

   localparam int MAX_OUT = 4;

   logic        CLK;
   logic        nRESET;
   logic        burst_rd;
   logic [25:0] burst_addr;
   logic [10:0] burst_len;
   logic        burst_32bit;
   logic [31:0] burst_data;
   logic        burst_data_valid;
   logic        burst_data_done;
   logic        burst_busy;
   logic        burst_overrun;
   logic        mem_rd;
   logic [24:0] mem_addr;
   logic        mem_ready;
   logic [15:0] mem_q;
   logic        mem_q_valid;

   sdram_burst_responder #(.ADDR_W(26), .LEN_W(11), .MAX_OUT(MAX_OUT)) dut (
      .CLK              (CLK),
      .nRESET           (nRESET),
      .burst_rd         (burst_rd),
      .burst_addr       (burst_addr),
      .burst_len        (burst_len),
      .burst_32bit      (burst_32bit),
      .burst_data       (burst_data),
      .burst_data_valid (burst_data_valid),
      .burst_data_done  (burst_data_done),
      .burst_busy       (burst_busy),
      .burst_overrun    (burst_overrun),
      .mem_rd           (mem_rd),
      .mem_addr         (mem_addr),
      .mem_ready        (mem_ready),
      .mem_q            (mem_q),
      .mem_q_valid      (mem_q_valid)
   );

   typedef struct {
      int          due;
      logic [15:0] data;
   } resp_t;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // memory model
   logic [15:0] mem_img [logic [24:0]];
   resp_t       pend[$];
   int          lat = 3;
   int          ready_mode = 0;
   int          n_acc, first_acc, last_acc, n_resp = 0, max_inflight;

   // burst model
   bit          act = 0;
   int          t_acc, act_from, m_len, done_due = -1;
   bit          ovr_set = 0;
   int          ovr_cyc;
   logic [24:0] exp_addr[$];
   logic [31:0] exp_beats[$];
   logic [24:0] addr_log[$];
   logic [31:0] beat_log[$];
   int          last_valid_cyc, done_cyc;

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc++;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] mem_hw(input logic [24:0] a);
      if (mem_img.exists(a)) return mem_img[a];
      return 16'(a) ^ 16'hC3C3;
   endfunction

   // Per-cycle compare against the model, then drive the memory side.
   always @(negedge CLK) begin : cmp_mem
      int inflight;
      inflight = pend.size();
      if (!nRESET) begin
         chk("reset_outputs",
             64'({burst_data, burst_data_valid, burst_data_done, burst_busy,
                  burst_overrun, mem_rd, mem_addr}), 64'(0));
      end else begin
         chk("busy", 64'(burst_busy), 64'(act && cyc >= act_from));
         chk("done", 64'(burst_data_done), 64'(act && cyc == done_due));
         chk("overrun", 64'(burst_overrun), 64'(ovr_set && cyc > ovr_cyc));
         if (act && cyc == t_acc + 1 && m_len != 0)
            chk("first_rd", 64'(mem_rd), 64'(1));
         if (mem_rd)
            chk("inflight_limit", 64'(inflight < MAX_OUT), 64'(1));
         if (burst_data_valid) begin
            chk("beat_expected", 64'(exp_beats.size() != 0), 64'(1));
            beat_log.push_back(burst_data);
            last_valid_cyc = cyc;
            if (exp_beats.size() != 0) begin
               chk("beat_data", 64'(burst_data), 64'(exp_beats[0]));
               void'(exp_beats.pop_front());
               if (exp_beats.size() == 0) done_due = cyc + 1;
            end
         end
      end
      if (inflight > max_inflight) max_inflight = inflight;

      mem_ready = (ready_mode == 0) || ((cyc % 3) != 1);
      if (nRESET && mem_rd && mem_ready) begin
         chk("rd_expected", 64'(exp_addr.size() != 0), 64'(1));
         if (exp_addr.size() != 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr[0]));
            void'(exp_addr.pop_front());
         end
         addr_log.push_back(mem_addr);
         if (n_acc == 0) first_acc = cyc;
         last_acc = cyc;
         n_acc++;
         pend.push_back('{due: cyc + lat, data: mem_hw(mem_addr)});
      end
      if (pend.size() != 0 && pend[0].due == cyc) begin
         mem_q_valid = 1'b1;
         mem_q       = pend[0].data;
         void'(pend.pop_front());
         n_resp++;
      end else begin
         mem_q_valid = 1'b0;
         mem_q       = 16'($urandom);
      end
      if (act && cyc == done_due) act = 0;
   end

   // Pulse burst_rd for one cycle; if the model is idle, record the expected burst.
   task automatic start_burst(input logic [25:0] addr, input int len, input logic m32);
      burst_addr  = addr;
      burst_len   = 11'(len);
      burst_32bit = m32;
      burst_rd    = 1'b1;
      if (act) begin
         ovr_set = 1;
         ovr_cyc = cyc;
      end else begin
         logic [24:0] a;
         logic [15:0] hws[$];
         logic [15:0] lo;
         act      = 1;
         t_acc    = cyc;
         act_from = cyc + 1;
         m_len    = len;
         done_due = (len == 0) ? cyc + 1 : -1;
         exp_addr.delete();
         exp_beats.delete();
         addr_log.delete();
         beat_log.delete();
         n_acc        = 0;
         max_inflight = 0;
         a = addr[25:1];
         for (int i = 0; i < len; i++) begin
            exp_addr.push_back(a);
            hws.push_back(mem_hw(a));
            a = a + 25'd1;
         end
         if (m32) begin
            for (int i = 0; i < len; i += 2) begin
               lo = 16'h0;
               if (i + 1 < len) lo = hws[i+1];
               exp_beats.push_back({hws[i], lo});
            end
         end else begin
            for (int i = 0; i < len; i++) exp_beats.push_back({16'h0, hws[i]});
         end
      end
      @(posedge CLK); #1;
      burst_rd = 1'b0;
   endtask

   task automatic run_to_done(input int budget);
      bit seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (burst_data_done) begin
            seen     = 1;
            done_cyc = cyc;
            break;
         end
         @(posedge CLK); #1;
      end
      chk("done_seen", 64'(seen), 64'(1));
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK); #1;
      end
   endtask

   initial begin : stim
      int resp_base;
      CLK = 0; nRESET = 0;
      burst_rd = 0; burst_addr = '0; burst_len = '0; burst_32bit = 0;
      mem_ready = 0; mem_q = '0; mem_q_valid = 0;
      mem_img[25'h80]  = 16'h1111; mem_img[25'h81]  = 16'h2222;
      mem_img[25'h82]  = 16'h3333; mem_img[25'h83]  = 16'h4444;
      mem_img[25'h100] = 16'hAAAA; mem_img[25'h101] = 16'hBBBB;
      mem_img[25'h102] = 16'hCCCC;
      mem_img[25'h180] = 16'h5555; mem_img[25'h181] = 16'h6666;
      for (int i = 0; i < 8; i++) mem_img[25'h800 + 25'(i)] = 16'h1000 + 16'(i);

      repeat (3) @(posedge CLK);
      #2 nRESET = 1;
      idle(2);
      chk("reset_state",
          64'({burst_data, burst_data_valid, burst_data_done, burst_busy,
               burst_overrun, mem_rd, mem_addr}), 64'(0));

      // len 4, 32-bit, latency 3
      lat = 3; ready_mode = 0;
      start_burst(26'h100, 4, 1);
      run_to_done(100);
      chk("t1_addr0", 64'(addr_log[0]), 64'h80);
      chk("t1_addr3", 64'(addr_log[3]), 64'h83);
      chk("t1_beat0", 64'(beat_log[0]), 64'h11112222);
      chk("t1_beat1", 64'(beat_log[1]), 64'h33334444);
      chk("t1_nbeats", 64'(beat_log.size()), 64'(2));
      chk("t1_done_lat", 64'(done_cyc - t_acc), 64'(9));
      chk("t1_done_after_beat", 64'(done_cyc - last_valid_cyc), 64'(1));
      chk("t1_first_rd", 64'(first_acc - t_acc), 64'(1));
      chk("t1_streamed", 64'(last_acc - first_acc), 64'(3));

      // back-to-back: len 3, 32-bit, in the first IDLE cycle after done
      @(posedge CLK); #1;
      start_burst(26'h200, 3, 1);
      run_to_done(100);
      chk("t2_beat0", 64'(beat_log[0]), 64'hAAAABBBB);
      chk("t2_beat1", 64'(beat_log[1]), 64'hCCCC0000);
      chk("t2_nbeats", 64'(beat_log.size()), 64'(2));

      // len 0
      idle(2);
      start_burst(26'h500, 0, 1);
      run_to_done(10);
      chk("t3_done_lat", 64'(done_cyc - t_acc), 64'(1));
      chk("t3_no_reads", 64'(addr_log.size()), 64'(0));
      idle(2);
      chk("t3_no_beats", 64'(beat_log.size()), 64'(0));

      // in-flight cap: latency 10, len 8, 16-bit
      lat = 10;
      start_burst(26'h1000, 8, 0);
      run_to_done(200);
      chk("t4_max_inflight", 64'(max_inflight), 64'(MAX_OUT));
      chk("t4_beat0", 64'(beat_log[0]), 64'h00001000);
      chk("t4_beat7", 64'(beat_log[7]), 64'h00001007);
      chk("t4_nbeats", 64'(beat_log.size()), 64'(8));

      // sustained rate: latency 3 below the cap
      idle(2);
      lat = 3;
      start_burst(26'h1000, 8, 0);
      run_to_done(100);
      chk("t4b_streamed", 64'(last_acc - first_acc), 64'(7));

      // overrun mid-burst with stalling memory
      idle(2);
      lat = 2; ready_mode = 1;
      start_burst(26'h400, 6, 1);
      idle(3);
      start_burst(26'h3000, 5, 0);
      run_to_done(200);
      chk("t5_overrun", 64'(burst_overrun), 64'(1));
      chk("t5_nbeats", 64'(beat_log.size()), 64'(3));
      chk("t5_nreads", 64'(addr_log.size()), 64'(6));

      // address wrap
      idle(2);
      lat = 1; ready_mode = 0;
      start_burst(26'h3FFFFFE, 3, 0);
      run_to_done(100);
      chk("t6_addr0", 64'(addr_log[0]), 64'h1FFFFFF);
      chk("t6_addr1", 64'(addr_log[1]), 64'h0);
      chk("t6_addr2", 64'(addr_log[2]), 64'h1);

      // reset with two reads outstanding; responses land after release
      idle(2);
      lat = 8;
      start_burst(26'h80, 8, 0);
      for (int i = 0; i < 50 && n_acc < 2; i++) @(posedge CLK);
      chk("t7_two_issued", 64'(n_acc), 64'(2));
      #2 nRESET = 0;
      act = 0; done_due = -1; ovr_set = 0;
      exp_addr.delete(); exp_beats.delete(); beat_log.delete();
      resp_base = n_resp;
      @(posedge CLK); @(posedge CLK);
      #2 nRESET = 1;
      for (int i = 0; i < 40 && pend.size() != 0; i++) @(posedge CLK);
      idle(3);
      chk("t7_stale_count", 64'(n_resp - resp_base), 64'(2));
      chk("t7_stale_no_beats", 64'(beat_log.size()), 64'(0));
      lat = 2;
      start_burst(26'h300, 2, 1);
      run_to_done(100);
      chk("t7_next_beat", 64'(beat_log[0]), 64'h55556666);
      chk("t7_next_nbeats", 64'(beat_log.size()), 64'(1));

      idle(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog timeout t=%0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
